// File: rtl/tx_gearbox.sv
// 66b-to-64b transmit gearbox.
// Packs {payload, header} blocks into a continuous 64-bit word stream.
// Thirty-two 66-bit blocks fill thirty-three words, so one cycle in every
// 33 is a pause in which only the buffered residual bits are sent and
// the upstream encoder/scrambler must hold.
module tx_gearbox (
  input  logic        i_txc,
  input  logic        i_reset,
  input  logic        i_init_done,
  input  logic [1:0]  i_header,
  input  logic [63:0] i_data,
  output logic        o_tx_pause,
  output logic [63:0] o_txd,
  output logic [5:0]  o_seq
);

  // Sequence value at which the residual holds a complete word.
  localparam logic [5:0] SEQ_PAUSE = 6'd32;

  logic [5:0]   seq_q, seq_d;
  logic [63:0]  residual_q, residual_d;
  logic [63:0]  txd_q, txd_d;
  logic         pause_q, pause_d;

  logic         hold_reset;
  logic         is_pause;
  logic [65:0]  block66;
  logic [5:0]   shamt;
  logic [127:0] shifted;

  // A transceiver that is not yet initialised is treated exactly as reset.
  assign hold_reset = i_reset | ~i_init_done;

  // Header occupies the two first-transmitted bits of the block.
  assign block66 = {i_data, i_header};

  assign is_pause = (seq_q == SEQ_PAUSE);

  // Each consumed block leaves two more bits behind, so the block is placed
  // above the 2*seq residual bits already waiting to go out.
  assign shamt   = {seq_q[4:0], 1'b0};
  assign shifted = {62'd0, block66} << shamt;

  // Next-state: emit low 64 bits of (block above residual), keep the rest.
  always_comb begin
    seq_d      = seq_q;
    residual_d = residual_q;
    txd_d      = txd_q;
    if (hold_reset) begin
      seq_d      = 6'd0;
      residual_d = 64'd0;
      txd_d      = 64'd0;
    end else if (is_pause) begin
      // Residual is a full word here; the input block is ignored.
      txd_d      = residual_q;
      residual_d = 64'd0;
      seq_d      = 6'd0;
    end else begin
      txd_d      = shifted[63:0] | residual_q;
      residual_d = shifted[127:64];
      seq_d      = seq_q + 6'd1;
    end
    // Pause is registered alongside seq so the output is glitch-free.
    pause_d = (seq_d == SEQ_PAUSE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_txc) begin
    if (hold_reset) begin
      seq_q      <= 6'd0;
      residual_q <= 64'd0;
      txd_q      <= 64'd0;
      pause_q    <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      residual_q <= residual_d;
      txd_q      <= txd_d;
      pause_q    <= pause_d;
    end
  end

  assign o_tx_pause = pause_q;
  assign o_txd      = txd_q;
  assign o_seq      = seq_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// Self-checking bench for tx_gearbox: bit-queue stream model plus
// directed literal checks of the spec's test scenarios.
module tb_tx_gearbox;

  logic        i_txc = 1'b0;
  logic        i_reset;
  logic        i_init_done;
  logic [1:0]  i_header;
  logic [63:0] i_data;
  logic        o_tx_pause;
  logic [63:0] o_txd;
  logic [5:0]  o_seq;

  int n_checks = 0;
  int n_fail   = 0;

  tx_gearbox dut (
    .i_txc       (i_txc),
    .i_reset     (i_reset),
    .i_init_done (i_init_done),
    .i_header    (i_header),
    .i_data      (i_data),
    .o_tx_pause  (o_tx_pause),
    .o_txd       (o_txd),
    .o_seq       (o_seq)
  );

  always #5 i_txc = ~i_txc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The serial stream is a queue of bits: every accepted block pushes its
  // 66 bits (header first), every output word pops 64 bits. Upstream is
  // allowed 32 blocks, then one pause, repeating from release.
  bit          mq[$];
  int          m_cnt = 0;
  logic [63:0] exp_txd   = 64'd0;
  logic        exp_pause = 1'b0;
  logic [5:0]  exp_seq   = 6'd0;

  always @(posedge i_txc) begin
    logic [65:0] blk;
    logic [63:0] w;
    if (i_reset || !i_init_done) begin
      mq.delete();
      m_cnt     = 0;
      exp_txd   = 64'd0;
      exp_pause = 1'b0;
      exp_seq   = 6'd0;
    end else begin
      if (m_cnt != 32) begin
        blk = {i_data, i_header};
        for (int b = 0; b < 66; b++) mq.push_back(blk[b]);
      end
      w = 64'd0;
      for (int b = 0; b < 64; b++) w[b] = (mq.size() > 0) ? mq.pop_front() : 1'b0;
      exp_txd   = w;
      m_cnt     = (m_cnt == 32) ? 0 : m_cnt + 1;
      exp_seq   = 6'(m_cnt);
      exp_pause = (m_cnt == 32);
    end
  end

  // Compare DUT outputs with the model every cycle, away from the edge.
  always @(negedge i_txc) begin
    check("model_txd",   o_txd,               exp_txd);
    check("model_pause", 64'(o_tx_pause),     64'(exp_pause));
    check("model_seq",   64'(o_seq),          64'(exp_seq));
  end

  // ---------------- stimulus ----------------
  // Next block: poison during pause cycles, random otherwise.
  task automatic drive_next();
    if (o_tx_pause) begin
      i_header = 2'b11;
      i_data   = 64'hDEADBEEF_DEADBEEF;
    end else begin
      i_header = 2'($urandom);
      i_data   = {$urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(posedge i_txc);
    #1;
  endtask

  initial begin
    logic [63:0] one;
    logic [63:0] wexp;
    int          m;
    int          cnt;
    bit          found;

    one         = 64'h1;
    i_reset     = 1'b1;
    i_init_done = 1'b1;
    i_header    = 2'b00;
    i_data      = 64'd0;
    repeat (3) tick();
    check("reset_txd",   o_txd,           64'h0);
    check("reset_pause", 64'(o_tx_pause), 64'h0);
    check("reset_seq",   64'(o_seq),      64'h0);

    // Constant header 01, payload 0: word n = 1 << 2n, then an empty word.
    i_header = 2'b01;
    i_data   = 64'd0;
    i_reset  = 1'b0;
    for (int n = 0; n < 198; n++) begin
      tick();
      m    = n % 33;
      wexp = (m == 32) ? 64'h0 : (one << (2 * m));
      check("const_txd",   o_txd,           wexp);
      check("const_seq",   64'(o_seq),      64'((n + 1) % 33));
      check("const_pause", 64'(o_tx_pause), 64'(m == 31));
    end

    // Random stream with poisoned pause cycles; the model checks every word.
    for (int n = 0; n < 10000; n++) begin
      drive_next();
      tick();
    end

    // Reset for one cycle at seq 17.
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (o_seq == 6'd17) found = 1;
      else begin
        drive_next();
        tick();
      end
    end
    check("seq17_reached", 64'(found), 64'h1);
    i_reset = 1'b1;
    tick();
    check("midrst_txd",   o_txd,           64'h0);
    check("midrst_seq",   64'(o_seq),      64'h0);
    check("midrst_pause", 64'(o_tx_pause), 64'h0);
    i_reset  = 1'b0;
    i_header = 2'b10;
    i_data   = 64'h0123456789ABCDEF;
    tick();
    check("midrst_first_word", o_txd, 64'h048D159E26AF37BE);
    cnt = 1;
    while (!o_tx_pause && cnt < 40) begin
      drive_next();
      tick();
      cnt++;
    end
    check("midrst_pause_delay", 64'(cnt), 64'd32);

    // init_done low for five cycles at seq 31.
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (o_seq == 6'd31) found = 1;
      else begin
        drive_next();
        tick();
      end
    end
    check("seq31_reached", 64'(found), 64'h1);
    i_init_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive_next();
      tick();
      check("initlow_txd",   o_txd,           64'h0);
      check("initlow_seq",   64'(o_seq),      64'h0);
      check("initlow_pause", 64'(o_tx_pause), 64'h0);
    end
    i_init_done = 1'b1;
    i_header    = 2'b01;
    i_data      = 64'hFFFF0000_FFFF0000;
    tick();
    check("initrise_first_word", o_txd, 64'hFFFC0003_FFFC0001);
    for (int n = 0; n < 40; n++) begin
      drive_next();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
